mdr_unit: RTL
=============

# mdr_unit

Memory Data Register stage with a memory request/acknowledge sequencer. It owns the 32-bit MDR value driven onto the datapath bus input `BusMuxInMDR` and loads it either from the bus (`BusMuxOut`) or from memory read data. It runs single-word read and write transactions against the memory port using a req/ack handshake with a timeout. It sits directly upstream of the bus multiplexer's MDR input and downstream of the MAR and control sequencer.

## Interface
- `DATA_WIDTH`, 32, width of MDR, bus and memory data.
- `ADDR_WIDTH`, 9, memory word address width.
- `TIMEOUT`, 255, maximum BUSY cycles waiting for `mem_ack` before abort; legal range 1..255.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `BusMuxOut`  in  DATA_WIDTH  current bus value.
- `MDRin`  in  1  load enable for a bus load into the MDR.
- `Read`  in  1  when 1, `MDRin` is ignored; the MDR is written only by read completion.
- `mem_start`  in  1  one-cycle request to begin a transaction; sampled only in IDLE.
- `mem_write`  in  1  direction sampled with `mem_start`: 1 = write, 0 = read.
- `MAR`  in  ADDR_WIDTH  address sampled with `mem_start`.
- `mem_req`  out  1  handshake request.
- `mem_we`  out  1  write strobe qualifier, valid while `mem_req`=1.
- `mem_addr`  out  ADDR_WIDTH  latched address.
- `mem_wdata`  out  DATA_WIDTH  latched write data (MDR snapshot at start).
- `mem_rdata`  in  DATA_WIDTH  read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  memory acknowledge.
- `BusMuxInMDR`  out  DATA_WIDTH  MDR contents to the bus multiplexer.
- `mem_busy`  out  1  high in BUSY.
- `mem_done`  out  1  one-cycle pulse on successful completion.
- `mem_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, BUSY, DONE, ERR. Reset state is IDLE.
- IDLE: `mem_start`=1 → latch `MAR`→`mem_addr`, `mem_write`→`mem_we`, MDR→`mem_wdata`; clear the timeout counter; go to BUSY. Otherwise stay in IDLE.
- BUSY: `mem_req`=1 and `mem_busy`=1. `mem_addr`, `mem_we` and `mem_wdata` are held stable.
  - `mem_ack`=1 → go to DONE. On a read, `mem_rdata` is loaded into the MDR at the same edge.
  - `mem_ack`=0 → increment the counter. When the counter equals `TIMEOUT`-1 on that edge, go to ERR; the MDR is unchanged.
- DONE: `mem_done`=1 for exactly one cycle, then IDLE.
- ERR: `mem_err`=1 for exactly one cycle, then IDLE.
- Bus load: `MDRin`=1 and `Read`=0 → MDR ← `BusMuxOut`. This is allowed in any state.
- Priority: a read-ack capture beats a bus load at the same edge; the bus load is dropped.
- A write transaction uses the MDR snapshot taken at start, so later MDR loads do not disturb `mem_wdata`.
- `mem_start` outside IDLE is ignored, with no queuing. `mem_ack` outside BUSY is ignored.
- `mem_ack` on the same edge the timeout would fire: the ack wins and the FSM goes to DONE.

## Timing
- Reset (`clear`=0, asynchronous, mid-transaction included):
  - State → IDLE.
  - MDR, `BusMuxInMDR`, `mem_addr`, `mem_wdata`, and the counter → 0.
  - `mem_req`, `mem_we`, `mem_busy`, `mem_done`, `mem_err` → 0 immediately, without waiting for a clock edge.
- `BusMuxInMDR` is the registered MDR and has no combinational path from any input.
- `mem_req` is asserted in the cycle after the edge that samples `mem_start`.
- Minimum latency: start sampled at edge N; ack high in the cycle after N; MDR updated and DONE entered at edge N+1; `mem_done` high between N+1 and N+2.
- `mem_req` falls at the edge that samples `mem_ack`. It is never high for more than `TIMEOUT` consecutive cycles.
- The next `mem_start` is accepted no earlier than the edge that leaves DONE or ERR. The back-to-back period is 3 cycles with immediate ack.
- Counter width is 8 bits and never wraps, since `TIMEOUT`≤255.

## Test plan
- Reset mid-read: start read, drop `clear` while BUSY → `mem_req`=0 asynchronously, `BusMuxInMDR`=0, state IDLE, no `mem_done`.
- Bus load: `BusMuxOut`=0xDEADBEEF, `MDRin`=1, `Read`=0 → `BusMuxInMDR`=0xDEADBEEF after one edge. Repeat with `Read`=1 → MDR unchanged.
- Read, zero-wait: `MAR`=0x01F, start, ack in the first BUSY cycle with `mem_rdata`=0x12345678 → MDR=0x12345678 at N+1, one `mem_done` pulse, `mem_addr`=0x01F while `mem_req`=1.
- Write with MDR change: MDR=0xA5A5A5A5, start write, load the MDR with 0x0 during BUSY, ack after 5 cycles → `mem_wdata`=0xA5A5A5A5 and `mem_we`=1 throughout; MDR ends at 0x0.
- Timeout: `TIMEOUT`=4, start read, no ack → `mem_req` high exactly 4 cycles, `mem_err` pulse, MDR unchanged. Repeat with ack on the 4th cycle → `mem_done`, not `mem_err`.
- Collisions: read ack coincides with `MDRin`=1/`Read`=0 → MDR = `mem_rdata`. `mem_start` asserted while BUSY → ignored, only one transaction completes.

Source files
------------

// File: rtl/mdr_unit_if.sv
// Memory port bundle between the MDR stage and the memory.
// The master issues req/we/addr/wdata and the slave answers with ack/rdata.
interface mdr_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/mdr_unit.sv
// Memory Data Register with a single-word req/ack memory sequencer.
// A read acknowledge has priority over a bus load of the MDR.
module mdr_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] BusMuxOut,
   input  logic                  MDRin,
   input  logic                  Read,
   input  logic                  mem_start,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] MAR,
   mdr_unit_if.master            mem,
   output logic [DATA_WIDTH-1:0] BusMuxInMDR,
   output logic                  mem_busy,
   output logic                  mem_done,
   output logic                  mem_err
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

   state_t                r_state;
   logic [7:0]            r_cnt;
   logic [DATA_WIDTH-1:0] r_mdr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic                  r_req;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic                  w_rd_cap;
   logic                  w_bus_ld;

   assign w_rd_cap = (r_state == BUSY) && mem.mem_ack && !r_we;
   assign w_bus_ld = MDRin && !Read;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_mdr   <= '0;
         r_wdata <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_rd_cap)
            r_mdr <= mem.mem_rdata;
         else if (w_bus_ld)
            r_mdr <= BusMuxOut;

         r_done <= 1'b0;
         r_err  <= 1'b0;

         unique case (r_state)
            IDLE: begin
               if (mem_start) begin
                  r_addr  <= MAR;
                  r_we    <= mem_write;
                  r_wdata <= r_mdr;
                  r_cnt   <= '0;
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               // Ack wins even on the edge where the timeout would fire.
               if (mem.mem_ack) begin
                  r_req   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
                  if (r_cnt == LP_LAST) begin
                     r_req   <= 1'b0;
                     r_busy  <= 1'b0;
                     r_err   <= 1'b1;
                     r_state <= ERR;
                  end
               end
            end
            DONE: r_state <= IDLE;
            ERR:  r_state <= IDLE;
         endcase
      end
   end

   assign mem.mem_req   = r_req;
   assign mem.mem_we    = r_we;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wdata = r_wdata;
   assign BusMuxInMDR   = r_mdr;
   assign mem_busy      = r_busy;
   assign mem_done      = r_done;
   assign mem_err       = r_err;

endmodule
